doodler_motion: RTL and testbench

Per-frame motion controller for the Doodle Jump player sprite. It sits directly upstream of the color mapper and produces `BallX`, `BallY`, `Ball_size` and `outstate` once per video frame. It applies horizontal keyboard steering with screen wrap, vertical gravity/jump physics and platform bounces, and runs a small game-state machine (idle / rising / falling / dead).

---
 rtl/doodle_pkg.sv | 26 ++
 rtl/frame_tick_sync.sv | 27 ++
 rtl/doodler_motion.sv | 164 ++++++++++++++++
 tb/tb_doodler_motion.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared types and constants for the Doodle Jump player motion logic.
package doodle_pkg;

  // Game state, encoded exactly as the color mapper expects on outstate.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRise = 3'd1,
    StFall = 3'd2,
    StDead = 3'd3
  } state_e;

  // USB HID keycodes used for steering and jumping.
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  // Visible screen dimensions in pixels.
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // True when the keycode is one of the two steering keys.
  function automatic logic is_steer_key(input logic [7:0] code);
    return (code == KEY_A) || (code == KEY_D);
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and produces a
// one-cycle tick on each synchronised rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q, sync2_q, prev_q;

  // Two-flop synchroniser followed by a previous-value flop for edge detect.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/doodler_motion.sv
// Per-frame motion controller for the player sprite: steering with screen
// wrap, gravity/jump physics, platform bounces and the game-state machine.
module doodler_motion
  import doodle_pkg::*;
#(
  parameter int unsigned X_START  = 320,
  parameter int unsigned Y_START  = 400,
  parameter int unsigned SIZE     = 4,
  parameter int unsigned X_MAX    = SCREEN_W - 1,
  parameter int unsigned Y_MAX    = SCREEN_H - 1,
  parameter int unsigned X_STEP   = 3,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned MAX_FALL = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       land,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic [2:0] outstate
);

  // Constants in the widths the datapath works in.
  localparam logic [9:0]         XStart   = 10'(X_START);
  localparam logic [9:0]         YStart   = 10'(Y_START);
  localparam logic [9:0]         XMax10   = 10'(X_MAX);
  localparam logic [9:0]         YDead    = 10'(Y_MAX - SIZE);
  localparam logic signed [11:0] XStepS   = 12'(X_STEP);
  localparam logic signed [11:0] XMaxS    = 12'(X_MAX);
  localparam logic signed [11:0] YMaxS    = 12'(Y_MAX);
  localparam logic signed [11:0] SizeS    = 12'(SIZE);
  localparam logic signed [11:0] GravS    = 12'(GRAVITY);
  localparam logic signed [11:0] MaxFallS = 12'(MAX_FALL);
  localparam logic signed [10:0] MaxFall  = 11'(MAX_FALL);
  localparam logic signed [10:0] VyJump   = 11'(-int'(JUMP_V));

  logic tick;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [10:0] vy_q, vy_d;

  // Candidate motion results for a RISE/FALL frame.
  logic signed [11:0] x_ext, x_sum;
  logic [9:0]         x_next;
  logic signed [11:0] y_sum, y_move;
  logic               y_ceil;
  logic signed [11:0] vy_base, vy_inc;
  logic signed [10:0] vy_next;
  logic               hit_floor;

  // Horizontal step and wrap, vertical move with ceiling clamp, gravity.
  always_comb begin
    x_ext = $signed({2'b00, x_q});
    x_sum = x_ext;
    if (is_steer_key(keycode)) begin
      x_sum = (keycode == KEY_A) ? (x_ext - XStepS) : (x_ext + XStepS);
    end
    if (x_sum < 0) begin
      x_next = XMax10;
    end else if (x_sum > XMaxS) begin
      x_next = 10'd0;
    end else begin
      x_next = x_sum[9:0];
    end

    y_sum  = $signed({2'b00, y_q}) + $signed({vy_q[10], vy_q});
    y_ceil = (y_sum < SizeS);
    y_move = y_ceil ? SizeS : y_sum;

    // Hitting the ceiling kills upward speed before gravity is applied.
    vy_base = y_ceil ? 12'sd0 : $signed({vy_q[10], vy_q});
    vy_inc  = vy_base + GravS;
    vy_next = (vy_inc > MaxFallS) ? MaxFall : vy_inc[10:0];

    hit_floor = ((y_move + SizeS) >= YMaxS);
  end

  // Next-state logic for the game FSM and motion registers.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (keycode == KEY_SPACE) begin
            state_d = StRise;
            vy_d    = VyJump;
          end
        end
        StRise: begin
          x_d  = x_next;
          y_d  = y_move[9:0];
          vy_d = vy_next;
          if (!vy_next[10]) state_d = StFall;
        end
        StFall: begin
          x_d = x_next;
          // A landing wins over death in the same frame; Y is held on bounce.
          if (land) begin
            vy_d    = VyJump;
            state_d = StRise;
          end else if (hit_floor) begin
            y_d     = YDead;
            vy_d    = vy_next;
            state_d = StDead;
          end else begin
            y_d  = y_move[9:0];
            vy_d = vy_next;
          end
        end
        StDead: begin
          if (keycode == KEY_SPACE) begin
            state_d = StIdle;
            x_d     = XStart;
            y_d     = YStart;
            vy_d    = '0;
          end
        end
        default: begin
          state_d = StIdle;
          x_d     = XStart;
          y_d     = YStart;
          vy_d    = '0;
        end
      endcase
    end
  end

  // State, position and velocity registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      x_q     <= XStart;
      y_q     <= YStart;
      vy_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
    end
  end

  assign BallX     = x_q;
  assign BallY     = y_q;
  assign Ball_size = 10'(SIZE);
  assign outstate  = state_q;

endmodule

// File: tb/tb_doodler_motion.sv
// Directed bench for doodler_motion with hand-computed expected values.
module tb_doodler_motion;

  logic       clk;
  logic       rst_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       land;
  logic [9:0] ball_x, ball_y, ball_size;
  logic [2:0] outstate;

  int n_cmp;
  int n_err;

  doodler_motion dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .land      (land),
    .BallX     (ball_x),
    .BallY     (ball_y),
    .Ball_size (ball_size),
    .outstate  (outstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [2:0] st);
    chk({tag, ".x"}, 16'(ball_x), 16'(x));
    chk({tag, ".y"}, 16'(ball_y), 16'(y));
    chk({tag, ".st"}, 16'(outstate), 16'(st));
  endtask

  // One full frame strobe: rise, hold long enough to sync, fall, settle.
  task automatic frame();
    @(negedge clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    land      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values, and held with no frame strobe.
    @(negedge clk);
    chk_all("rst", 10'd320, 10'd400, 3'd0);
    chk("rst.size", 16'(ball_size), 16'd4);
    repeat (50) @(negedge clk);
    chk_all("rst_hold", 10'd320, 10'd400, 3'd0);

    // Latency: rise before edge 1, new outputs only after edge 3.
    keycode = 8'h2C;
    @(negedge clk);
    frame_clk = 1'b1;
    @(posedge clk); #1;
    chk("lat.e1", 16'(outstate), 16'd0);
    @(posedge clk); #1;
    chk("lat.e2", 16'(outstate), 16'd0);
    @(posedge clk); #1;
    chk("lat.e3", 16'(outstate), 16'd1);
    // Held high: no second tick, so no RISE motion.
    keycode = 8'h00;
    repeat (10) @(negedge clk);
    chk_all("no_retick", 10'd320, 10'd400, 3'd1);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);

    // Jump arc (tick 1 was the space above).
    frame();  chk_all("arc.t2", 10'd320, 10'd388, 3'd1);
    frame();  chk("arc.t3", 16'(ball_y), 16'd377);
    frame();  chk("arc.t4", 16'(ball_y), 16'd367);
    frames(8); chk_all("arc.t12", 10'd320, 10'd323, 3'd1);
    frame();  chk_all("arc.t13", 10'd320, 10'd322, 3'd2);
    frames(10); chk("arc.t23", 16'(ball_y), 16'd367);
    frame();  chk("arc.t24", 16'(ball_y), 16'd377);
    frame();  chk("arc.t25_sat", 16'(ball_y), 16'd387);
    frames(6); chk_all("arc.t31", 10'd320, 10'd447, 3'd2);
    frames(2); chk_all("arc.t33", 10'd320, 10'd467, 3'd2);
    frame();  chk_all("death", 10'd320, 10'd475, 3'd3);

    // DEAD is frozen, space respawns.
    keycode = 8'h07;
    frame();  chk_all("dead_frozen", 10'd320, 10'd475, 3'd3);
    keycode = 8'h2C;
    frame();  chk_all("respawn", 10'd320, 10'd400, 3'd0);

    // Reset asserted mid-RISE takes effect immediately.
    frame();  chk("rr.rise", 16'(outstate), 16'd1);
    keycode = 8'h00;
    frame();  chk("rr.y", 16'(ball_y), 16'd388);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 10'd320, 10'd400, 3'd0);
    chk("rst_mid.size", 16'(ball_size), 16'd4);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Bounce from FALL with vel_y = 5; land ignored in RISE.
    keycode = 8'h2C;
    frame();
    keycode = 8'h00;
    frames(17); chk_all("pre_bounce", 10'd320, 10'd332, 3'd2);
    land = 1'b1;
    frame();  chk_all("bounce", 10'd320, 10'd332, 3'd1);
    frame();  chk_all("land_in_rise", 10'd320, 10'd320, 3'd1);
    land = 1'b0;

    // Landing beats death in the same frame.
    pulse_reset();
    keycode = 8'h2C;
    frame();
    keycode = 8'h00;
    frames(32); chk_all("pre_edge", 10'd320, 10'd467, 3'd2);
    land = 1'b1;
    frame();  chk_all("land_beats_death", 10'd320, 10'd467, 3'd1);
    land = 1'b0;

    // Wrap: bounce continuously with land held, steer right then left.
    pulse_reset();
    land    = 1'b1;
    keycode = 8'h2C;
    frame();
    keycode = 8'h07;
    frames(106); chk("wrap.pre", 16'(ball_x), 16'd638);
    frame();  chk_all("wrap.right", 10'd0, 10'd4, 3'd1);
    keycode = 8'h04;
    frame();  chk_all("wrap.left", 10'd639, 10'd4, 3'd2);
    keycode = 8'h00;
    land    = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
